uart_rx_deser: RTL and testbench

//  UART receive front end: oversamples the asynchronous rx_bit line and recovers 8N1 frames, LSB first.

---
 rtl/uart_rx_deser_pkg.sv | 22 ++
 rtl/uart_rx_deser_baud_tick.sv | 27 ++
 rtl/uart_rx_deser.sv | 154 +++++++++++++++
 tb/tb_uart_rx_deser.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_deser_pkg.sv
// Shared UART definitions: receiver FSM encoding, oversample default,
// register map and the majority vote used by the bit sampler.
package uart_rx_deser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  localparam int OVERSAMPLE_DEFAULT = 16;

  localparam logic [7:0] UART_ADDR_DATA   = 8'h00;
  localparam logic [7:0] UART_ADDR_STATUS = 8'h04;
  localparam logic [7:0] UART_ADDR_DIV    = 8'h08;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_deser_baud_tick.sv
// Sample-tick generator: one-cycle tick every freq_div+1 clocks.
// Shared with the TX serializer.
module uart_baud_tick #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 wb_clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] freq_div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] count;

  assign tick = (count == freq_div);

  // A count above a newly lowered freq_div simply wraps through its max.
  always_ff @(posedge wb_clk) begin
    if (reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_deser.sv
// UART 8N1 receive front end: synchronizer, oversampling FSM with 2-of-3
// voting, LSB-first shift register and a one-entry valid/ready holding register.
module uart_rx_deser
  import uart_rx_deser_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                 wb_clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] freq_div,
  input  logic                 rx_bit,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam int MID   = OVERSAMPLE / 2;

  localparam logic [OS_W-1:0]  OS_ONE   = OS_W'(1);
  localparam logic [OS_W-1:0]  OS_PRE   = OS_W'(MID - 1);
  localparam logic [OS_W-1:0]  OS_MID   = OS_W'(MID);
  localparam logic [OS_W-1:0]  OS_DEC   = OS_W'(MID + 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  rx_state_t            state, state_next;
  logic                 tick;
  logic                 rx_meta, rx_s;
  logic [OS_W-1:0]      os_cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic                 armed;
  logic                 samp_a, samp_b;
  logic                 decision;
  logic                 at_dec, at_last;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 deliver_pend;

  uart_baud_tick #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud_tick (
    .wb_clk   (wb_clk),
    .reset    (reset),
    .freq_div (freq_div),
    .tick     (tick)
  );

  assign decision = majority3(samp_a, samp_b, rx_s);
  assign at_dec   = tick && (os_cnt == OS_DEC);
  assign at_last  = tick && (os_cnt == OS_LAST);

  always_ff @(posedge wb_clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (tick && armed && !rx_s) state_next = ST_START;
      ST_START: begin
        if (at_dec && decision) begin
          state_next = ST_IDLE;
        end else if (at_last) begin
          state_next = ST_DATA;
        end
      end
      ST_DATA:  if (at_last && (bit_idx == BIT_LAST)) state_next = ST_STOP;
      ST_STOP:  if (at_dec) state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
  end

  // After a bad stop bit, armed stays low until the line is seen idle again,
  // so a held break yields a single frame error.
  always_ff @(posedge wb_clk) begin
    if (reset) begin
      rx_meta      <= 1'b1;
      rx_s         <= 1'b1;
      os_cnt       <= '0;
      bit_idx      <= '0;
      armed        <= 1'b1;
      samp_a       <= 1'b0;
      samp_b       <= 1'b0;
      shift_reg    <= '0;
      deliver_pend <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      rx_meta      <= rx_bit;
      rx_s         <= rx_meta;
      deliver_pend <= 1'b0;
      frame_err    <= 1'b0;
      if (tick) begin
        if (state == ST_IDLE) begin
          if (rx_s) armed <= 1'b1;
          if (armed && !rx_s) os_cnt <= OS_ONE;
          bit_idx <= '0;
        end else begin
          os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
          if (os_cnt == OS_PRE) samp_a <= rx_s;
          if (os_cnt == OS_MID) samp_b <= rx_s;
        end
        if (state == ST_DATA && os_cnt == OS_DEC) begin
          shift_reg <= {decision, shift_reg[DATA_BITS-1:1]};
        end
        if (state == ST_DATA && os_cnt == OS_LAST) begin
          bit_idx <= bit_idx + 1'b1;
        end
        if (state == ST_STOP && os_cnt == OS_DEC) begin
          if (decision) begin
            deliver_pend <= 1'b1;
          end else begin
            frame_err <= 1'b1;
            armed     <= 1'b0;
          end
        end
      end
    end
  end

  // A consumer taking the old byte in the delivery cycle frees the slot.
  always_ff @(posedge wb_clk) begin
    if (reset) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (deliver_pend) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift_reg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser: drives 8N1 frames bit-by-bit and checks
// delivered bytes, error pulses and handshake behaviour against fixed values.
module tb_uart_rx_deser;

  logic       wb_clk;
  logic       reset;
  logic [7:0] freq_div;
  logic       rx_bit;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int         checks;
  int         errors;
  int         valid_cycles;
  int         ferr_cnt;
  int         ovr_cnt;
  logic [7:0] acc_q[$];

  uart_rx_deser #(
    .DATA_BITS  (8),
    .OVERSAMPLE (16),
    .DIV_WIDTH  (8)
  ) dut (
    .wb_clk    (wb_clk),
    .reset     (reset),
    .freq_div  (freq_div),
    .rx_bit    (rx_bit),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  // Outputs are observed mid-cycle; inputs change 2 time units after posedge.
  always @(negedge wb_clk) begin
    if (rx_valid) valid_cycles++;
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
    if (rx_valid && rx_ready) acc_q.push_back(rx_data);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge wb_clk);
    #2;
  endtask

  task automatic clearMonitor();
    valid_cycles = 0;
    ferr_cnt     = 0;
    ovr_cnt      = 0;
    acc_q.delete();
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stop_val,
                               input int bit_cycles);
    rx_bit = 1'b0;
    waitCycles(bit_cycles);
    for (int i = 0; i < 8; i++) begin
      rx_bit = data[i];
      waitCycles(bit_cycles);
    end
    rx_bit = stop_val;
    waitCycles(bit_cycles);
  endtask

  initial begin
    logic [7:0] burst [3];
    int         bit_times [3];
    checks   = 0;
    errors   = 0;
    clearMonitor();
    reset    = 1'b1;
    freq_div = 8'd0;
    rx_bit   = 1'b1;
    rx_ready = 1'b0;
    waitCycles(5);

    checkOutput("reset_valid", 32'(rx_valid), 0);
    checkOutput("reset_data", 32'(rx_data), 0);
    checkOutput("reset_ferr", 32'(frame_err), 0);
    checkOutput("reset_ovr", 32'(overrun), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    reset = 1'b0;
    waitCycles(20);

    $display("[TB] single frame 0xA5");
    rx_ready = 1'b1;
    clearMonitor();
    fork
      applyStimulus(8'hA5, 1'b1, 16);
      begin
        waitCycles(80);
        checkOutput("t1_busy_mid", 32'(busy), 1);
      end
    join
    checkOutput("t1_busy_end", 32'(busy), 0);
    waitCycles(40);
    checkOutput("t1_count", acc_q.size(), 1);
    checkOutput("t1_data", 32'(acc_q[0]), 'hA5);
    checkOutput("t1_valid_cycles", valid_cycles, 1);
    checkOutput("t1_ferr", ferr_cnt, 0);
    checkOutput("t1_ovr", ovr_cnt, 0);

    $display("[TB] false start");
    clearMonitor();
    rx_bit = 1'b0;
    waitCycles(4);
    checkOutput("t2_busy_start", 32'(busy), 1);
    rx_bit = 1'b1;
    waitCycles(10);
    checkOutput("t2_busy_end", 32'(busy), 0);
    waitCycles(40);
    checkOutput("t2_valid_cycles", valid_cycles, 0);
    checkOutput("t2_ferr", ferr_cnt, 0);

    $display("[TB] framing error then break");
    clearMonitor();
    applyStimulus(8'h3C, 1'b0, 16);
    waitCycles(200);
    checkOutput("t3_ferr", ferr_cnt, 1);
    checkOutput("t3_valid_cycles", valid_cycles, 0);
    checkOutput("t3_busy", 32'(busy), 0);
    rx_bit = 1'b1;
    waitCycles(32);
    applyStimulus(8'h7E, 1'b1, 16);
    waitCycles(40);
    checkOutput("t3_count", acc_q.size(), 1);
    checkOutput("t3_data", 32'(acc_q[0]), 'h7E);
    checkOutput("t3_ferr_after", ferr_cnt, 1);

    $display("[TB] overrun and handshake");
    rx_ready = 1'b0;
    clearMonitor();
    applyStimulus(8'h11, 1'b1, 16);
    applyStimulus(8'h22, 1'b1, 16);
    waitCycles(40);
    checkOutput("t4_valid", 32'(rx_valid), 1);
    checkOutput("t4_data", 32'(rx_data), 'h11);
    checkOutput("t4_ovr", ovr_cnt, 1);
    checkOutput("t4_count_none", acc_q.size(), 0);
    rx_ready = 1'b1;
    waitCycles(1);
    checkOutput("t4_valid_drop", 32'(rx_valid), 0);
    checkOutput("t4_accepted", 32'(acc_q[0]), 'h11);
    rx_ready = 1'b0;
    waitCycles(20);
    clearMonitor();
    applyStimulus(8'h33, 1'b1, 16);
    waitCycles(40);
    checkOutput("t4_hold_33", 32'(rx_data), 'h33);
    fork
      applyStimulus(8'h22, 1'b1, 16);
      begin
        waitCycles(156);
        rx_ready = 1'b1;
        waitCycles(1);
        rx_ready = 1'b0;
      end
    join
    waitCycles(40);
    checkOutput("t4_swap_valid", 32'(rx_valid), 1);
    checkOutput("t4_swap_data", 32'(rx_data), 'h22);
    checkOutput("t4_swap_ovr", ovr_cnt, 0);
    checkOutput("t4_swap_count", acc_q.size(), 1);
    checkOutput("t4_swap_taken", 32'(acc_q[0]), 'h33);
    rx_ready = 1'b1;
    waitCycles(4);

    $display("[TB] freq_div=3 bursts");
    freq_div  = 8'd3;
    burst     = '{8'h00, 8'hFF, 8'h55};
    bit_times = '{64, 62, 66};
    waitCycles(20);
    for (int r = 0; r < 3; r++) begin
      clearMonitor();
      for (int f = 0; f < 3; f++) applyStimulus(burst[f], 1'b1, bit_times[r]);
      waitCycles(200);
      checkOutput($sformatf("t5_count_%0d", bit_times[r]), acc_q.size(), 3);
      for (int f = 0; f < 3; f++) begin
        checkOutput($sformatf("t5_data_%0d_%0d", bit_times[r], f), 32'(acc_q[f]),
                    32'(burst[f]));
      end
      checkOutput($sformatf("t5_ferr_%0d", bit_times[r]), ferr_cnt, 0);
    end

    $display("[TB] reset mid-frame");
    freq_div = 8'd0;
    waitCycles(20);
    fork
      applyStimulus(8'h99, 1'b1, 16);
      begin
        waitCycles(88);
        checkOutput("t6_busy_pre", 32'(busy), 1);
        reset = 1'b1;
        waitCycles(1);
        checkOutput("t6_valid", 32'(rx_valid), 0);
        checkOutput("t6_data", 32'(rx_data), 0);
        checkOutput("t6_ferr", 32'(frame_err), 0);
        checkOutput("t6_ovr", 32'(overrun), 0);
        checkOutput("t6_busy", 32'(busy), 0);
      end
    join
    waitCycles(2);
    reset = 1'b0;
    waitCycles(32);
    clearMonitor();
    applyStimulus(8'h5A, 1'b1, 16);
    waitCycles(40);
    checkOutput("t6_count", acc_q.size(), 1);
    checkOutput("t6_data_after", 32'(acc_q[0]), 'h5A);
    checkOutput("t6_ferr_after", ferr_cnt, 0);
    checkOutput("t6_ovr_after", ovr_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
